// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed from operands latched at acceptance and committed when the busy countdown expires.
module mult_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [3:0]       op_q,    op_d;
    logic [31:0]      a_q,     a_d;
    logic [31:0]      b_q,     b_d;
    logic [31:0]      hi_q,    hi_d;
    logic [31:0]      lo_q,    lo_d;

    // Result datapath, driven only by latched operands
    logic [63:0] prod_s, prod_u;
    logic        div_zero;
    logic [31:0] b_safe, a_mag, b_mag, q_mag, r_mag;
    logic [31:0] q_s, r_s, q_u, r_u;

    always_comb begin
        prod_s   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u   = {32'd0, a_q} * {32'd0, b_q};
        div_zero = (b_q == 32'd0);
        // A zero divisor is replaced so the dividers never see /0; the result is discarded anyway.
        b_safe   = div_zero ? 32'd1 : b_q;
        a_mag    = a_q[31]    ? -a_q    : a_q;
        b_mag    = b_safe[31] ? -b_safe : b_safe;
        q_mag    = a_mag / b_mag;
        r_mag    = a_mag % b_mag;
        // 0x80000000 / -1 wraps back to 0x80000000 through this negation.
        q_s      = (a_q[31] ^ b_safe[31]) ? -q_mag : q_mag;
        r_s      = a_q[31] ? -r_mag : r_mag;
        q_u      = a_q / b_safe;
        r_u      = a_q % b_safe;
    end

    always_comb begin
        // NOTE: every signal gets a default here so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    case (MDUOp)
                        OP_MULT, OP_MULTU: begin
                            state_d = RUN;
                            cnt_d   = CNT_W'(MUL_CYCLES);
                            op_d    = MDUOp;
                            a_d     = SrcA;
                            b_d     = SrcB;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = RUN;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            op_d    = MDUOp;
                            a_d     = SrcA;
                            b_d     = SrcB;
                        end
                        OP_MTHI: hi_d = SrcA;
                        OP_MTLO: lo_d = SrcA;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = prod_s;
                        OP_MULTU: {hi_d, lo_d} = prod_u;
                        OP_DIV: begin
                            if (!div_zero) begin
                                lo_d = q_s;
                                hi_d = r_s;
                            end
                        end
                        OP_DIVU: begin
                            if (!div_zero) begin
                                lo_d = q_u;
                                hi_d = r_u;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: all architectural and latched state is cleared by reset; there is no memory here that could be left unreset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy = (state_q == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed results, busy lengths, drop/ignore and reset cases.
module tb_mult_div_unit;

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] SrcA, SrcB;
    logic [3:0]  MDUOp;
    logic        Start;
    logic        Busy;
    logic [31:0] HI, LO;

    int n_cmp = 0;
    int n_err = 0;
    int n_busy;

    mult_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .SrcA    (SrcA),
        .SrcB    (SrcB),
        .MDUOp   (MDUOp),
        .Start   (Start),
        .Busy    (Busy),
        .HI      (HI),
        .LO      (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents an op for exactly one rising edge; returns 1 time unit after that edge.
    task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        MDUOp = op;
        SrcA  = a;
        SrcB  = b;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        MDUOp = 4'b0000;
    endtask

    // Counts post-edge samples with Busy high, starting from an already-consumed count.
    task automatic wait_idle(input int n_before, output int n);
        n = n_before;
        while (Busy && n < 200) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset_n = 1'b1;
        SrcA    = '0;
        SrcB    = '0;
        MDUOp   = '0;
        Start   = 1'b0;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_hi",   64'(HI),   64'd0);
        check("reset_lo",   64'(LO),   64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // MULT -2 * 3
        start_op(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_idle(0, n_busy);
        check("mult_busy", 64'(n_busy), 64'd5);
        check("mult_hi",   64'(HI), 64'hFFFF_FFFF);
        check("mult_lo",   64'(LO), 64'hFFFF_FFFA);

        // MULTU back-to-back with the previous completion
        start_op(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        check("b2b_accept", 64'(Busy), 64'd1);
        wait_idle(0, n_busy);
        check("multu_busy", 64'(n_busy), 64'd5);
        check("multu_hi",   64'(HI), 64'h0000_0001);
        check("multu_lo",   64'(LO), 64'hFFFF_FFFE);

        // DIV -7 / 2
        start_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_idle(0, n_busy);
        check("div_busy", 64'(n_busy), 64'd10);
        check("div_lo",   64'(LO), 64'hFFFF_FFFD);
        check("div_hi",   64'(HI), 64'hFFFF_FFFF);

        // DIVU 7 / 0 keeps HI/LO
        start_op(OP_DIVU, 32'h0000_0007, 32'h0000_0000);
        wait_idle(0, n_busy);
        check("div0_busy", 64'(n_busy), 64'd10);
        check("div0_lo",   64'(LO), 64'hFFFF_FFFD);
        check("div0_hi",   64'(HI), 64'hFFFF_FFFF);

        // DIV overflow corner
        start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(0, n_busy);
        check("divovf_lo", 64'(LO), 64'h8000_0000);
        check("divovf_hi", 64'(HI), 64'h0000_0000);

        // DIVU 100 / 7
        start_op(OP_DIVU, 32'd100, 32'd7);
        wait_idle(0, n_busy);
        check("divu_lo", 64'(LO), 64'd14);
        check("divu_hi", 64'(HI), 64'd2);

        // MTHI while idle
        start_op(OP_MTHI, 32'h1234_5678, 32'h0);
        check("mthi_busy", 64'(Busy), 64'd0);
        check("mthi_hi",   64'(HI), 64'h1234_5678);
        check("mthi_lo",   64'(LO), 64'd14);

        // MTLO dropped while a MULT 6*7 runs
        start_op(OP_MULT, 32'd6, 32'd7);
        @(posedge clk); #1;
        MDUOp = OP_MTLO;
        SrcA  = 32'hDEAD_BEEF;
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        MDUOp = 4'b0000;
        check("run_lo_hold", 64'(LO), 64'd14);
        check("run_hi_hold", 64'(HI), 64'h1234_5678);
        wait_idle(2, n_busy);
        check("mtlo_drop_busy", 64'(n_busy), 64'd5);
        check("mtlo_drop_lo",   64'(LO), 64'd42);
        check("mtlo_drop_hi",   64'(HI), 64'd0);

        // DIV 100 / -7 with operand churn and a second Start mid-run
        start_op(OP_DIV, 32'd100, 32'hFFFF_FFF9);
        @(posedge clk); #1;
        @(posedge clk); #1;
        SrcA = 32'd9;
        SrcB = 32'd4;
        @(posedge clk); #1;
        MDUOp = OP_DIVU;
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        MDUOp = 4'b0000;
        wait_idle(4, n_busy);
        check("churn_busy", 64'(n_busy), 64'd10);
        check("churn_lo",   64'(LO), 64'hFFFF_FFF2);
        check("churn_hi",   64'(HI), 64'd2);

        // Reserved and none codes do nothing
        start_op(4'b0111, 32'hAAAA_AAAA, 32'h1);
        check("rsvd_busy", 64'(Busy), 64'd0);
        start_op(4'b0000, 32'hBBBB_BBBB, 32'h1);
        check("none_busy", 64'(Busy), 64'd0);
        check("rsvd_hilo", {HI, LO}, {32'd2, 32'hFFFF_FFF2});

        // Reset in the middle of a MULT
        start_op(OP_MULT, 32'd1000, 32'd1000);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_hilo", {HI, LO}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        MDUOp = OP_MULTU;
        SrcA  = 32'd3;
        SrcB  = 32'd4;
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        MDUOp = 4'b0000;
        check("rst_first_accept", 64'(Busy), 64'd1);
        check("rst_no_stale", {HI, LO}, 64'd0);
        wait_idle(0, n_busy);
        check("rst_multu_busy", 64'(n_busy), 64'd5);
        check("rst_multu_lo",   64'(LO), 64'h0000_000C);
        check("rst_multu_hi",   64'(HI), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 5: Busy duration for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: Busy duration for DIV/DIVU.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port SrcA  input  32: operand A (rs); the dividend for DIV/DIVU.
REQ-006 SHALL have port SrcB  input  32: operand B (rt); the divisor for DIV/DIVU.
REQ-007 SHALL have port MDUOp  input  4: 0000 none, 0001 MULT, 0010 MULTU, 0011 DIV, 0100 DIVU, 0101 MTHI, 0110 MTLO; other codes are reserved.
REQ-008 SHALL have port Start  input  1: qualifies MDUOp for one cycle.
REQ-009 SHALL have port Busy  output  1: an operation is in progress.
REQ-010 SHALL have port HI  output  32: architectural HI register.
REQ-011 SHALL have port LO  output  32: architectural LO register.

Function
REQ-012 SHALL be a two-state FSM, IDLE/RUN, with a down-counter sized for max(MUL_CYCLES, DIV_CYCLES).
REQ-013 SHALL accept an operation only when Start=1 and Busy=0 at a rising edge.
REQ-014 SHALL, on an accepted MULT/MULTU/DIV/DIVU, latch SrcA, SrcB and the op, enter RUN, and load the counter with N (N = MUL_CYCLES for MULT/MULTU, DIV_CYCLES for DIV/DIVU).
REQ-015 SHALL hold Busy=1 for exactly N cycles after the accepting edge; Busy is combinationally equal to (state==RUN).
REQ-016 SHALL update HI/LO at the Nth edge after acceptance, return to IDLE on that edge, and leave HI/LO unchanged during RUN.
REQ-017 SHALL compute MULT as the signed 64-bit product {HI,LO} of the latched operands.
REQ-018 SHALL compute MULTU as the unsigned 64-bit product {HI,LO} of the latched operands.
REQ-019 SHALL compute DIV as LO = quotient truncated toward zero and HI = remainder carrying the dividend's sign.
REQ-020 SHALL compute DIV of 0x80000000 by 0xFFFFFFFF as LO=0x80000000, HI=0x00000000.
REQ-021 SHALL compute DIVU as LO = unsigned quotient and HI = unsigned remainder.
REQ-022 SHALL, on divide by zero (latched SrcB=0, DIV or DIVU), still run the full DIV_CYCLES Busy period and leave HI/LO unchanged.
REQ-023 SHALL, on an accepted MTHI/MTLO, write SrcA to HI or LO at that same edge without entering RUN (Busy stays 0).
REQ-024 SHALL ignore Start=1 while Busy=1 (op dropped, no state change, operands not re-latched).
REQ-025 SHALL treat Start=1 with op none or a reserved code as a no-op.
REQ-026 SHALL ignore SrcA/SrcB/MDUOp changes during RUN; results derive solely from the latched values.
REQ-027 SHALL allow back-to-back operation: a Start on the first cycle Busy=0 after completion is accepted, so the earliest next acceptance is the edge following the completion edge.

Reset
REQ-028 SHALL, while reset_n=0, asynchronously force state=IDLE, counter=0, Busy=0, HI=0, LO=0, and clear the latched operands.
REQ-029 SHALL, on reset_n asserted mid-RUN, abort the operation, with no HI/LO update after deassertion.
REQ-030 SHALL accept a Start first at the first rising edge after reset_n deasserts.

Verification
REQ-031 SHALL cover: MULT, SrcA=0xFFFFFFFE (-2), SrcB=0x00000003 -> Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-032 SHALL cover: MULTU, SrcA=0xFFFFFFFF, SrcB=0x00000002 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-033 SHALL cover: DIV, SrcA=0xFFFFFFF9 (-7), SrcB=0x00000002 -> Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIVU 7/0 -> Busy 10 cycles, HI/LO unchanged.
REQ-034 SHALL cover: MTHI SrcA=0x12345678 with Busy=0 -> HI=0x12345678 next cycle, Busy stays 0; MTLO issued during a MULT's Busy -> ignored, LO shows only the MULT result.
REQ-035 SHALL cover: DIV started, operands changed on cycle 3, second Start on cycle 4 -> result from the original operands only, Busy falls after 10 cycles.
REQ-036 SHALL cover: MULT started, reset_n pulled low on cycle 2 -> Busy=0, HI=LO=0 immediately; after release a new MULTU 3*4 -> LO=0x0000000C, HI=0.
